// File: rtl/power_sequencer.sv
// +----------------------------------------------------------------------------
// | Module   : power_sequencer
// | Purpose  : V6 rail enable, PG supervision, bounded retry and core-reset release.
// | Revision : 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

module power_sequencer #(
  parameter int CLK_PERIOD_NS   = 10,
  parameter int T_SETTLE_MS     = 1000,
  parameter int T_PG_TIMEOUT_MS = 100,
  parameter int T_READY_MS      = 1000,
  parameter int T_RETRY_MS      = 500,
  parameter int MAX_RETRIES     = 3,
  parameter int PG_FILT         = 16
) (
  input  logic       clk100,
  input  logic       pre_reset,
  input  logic       v3_pg,
  input  logic       v5p_pg,
  input  logic       v5n_pg,
  output logic       v6_en,
  output logic       init_ready,
  output logic       pg_ok,
  output logic       fault,
  output logic       lockout,
  output logic [2:0] retry_cnt,
  output logic [2:0] state
);

  localparam int          C_TICK_CYC   = 1_000_000 / CLK_PERIOD_NS;
  localparam int          C_PS_W       = $clog2(C_TICK_CYC + 1);
  localparam logic [C_PS_W-1:0] C_PS_LAST = C_PS_W'(C_TICK_CYC - 1);
  localparam logic [15:0] C_FILT_LAST  = 16'(PG_FILT - 1);
  localparam logic [15:0] C_T_SETTLE   = 16'(T_SETTLE_MS);
  localparam logic [15:0] C_T_TIMEOUT  = 16'(T_PG_TIMEOUT_MS);
  localparam logic [15:0] C_T_READY    = 16'(T_READY_MS);
  localparam logic [15:0] C_T_RETRY    = 16'(T_RETRY_MS);
  localparam logic [2:0]  C_MAX_RETRY  = 3'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_SETTLE = 3'd0,
    S_RAMP   = 3'd1,
    S_STABLE = 3'd2,
    S_READY  = 3'd3,
    S_OFF    = 3'd4,
    S_LOCK   = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_fault_entry;
  logic                w_state_chg;
  logic [2:0]          r_sync1;
  logic [2:0]          r_sync2;
  logic                w_pg_raw;
  logic [15:0]         r_filt_cnt;
  logic                r_pg_ok;
  logic [C_PS_W-1:0]   r_presc;
  logic                w_ms_tick;
  logic [15:0]         r_ms_cnt;
  logic                r_v6_en;
  logic                r_init_ready;
  logic                r_fault;
  logic                r_lockout;
  logic [2:0]          r_retry_cnt;

  assign w_pg_raw = &r_sync2;

  always_ff @(posedge clk100 or posedge pre_reset) begin
    if (pre_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {v3_pg, v5p_pg, v5n_pg};
      r_sync2 <= r_sync1;
    end
  end

  // Any cycle where the synced vector agrees with pg_ok restarts the count.
  always_ff @(posedge clk100 or posedge pre_reset) begin
    if (pre_reset) begin
      r_filt_cnt <= '0;
      r_pg_ok    <= 1'b0;
    end else if (w_pg_raw != r_pg_ok) begin
      if (r_filt_cnt == C_FILT_LAST) begin
        r_pg_ok    <= w_pg_raw;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 16'd1;
      end
    end else begin
      r_filt_cnt <= '0;
    end
  end

  assign w_ms_tick   = (r_presc == C_PS_LAST);
  assign w_state_chg = (w_next != r_state);

  always_ff @(posedge clk100 or posedge pre_reset) begin
    if (pre_reset) begin
      r_presc  <= '0;
      r_ms_cnt <= '0;
    end else if (w_state_chg) begin
      r_presc  <= '0;
      r_ms_cnt <= '0;
    end else begin
      r_presc <= w_ms_tick ? '0 : r_presc + 1'b1;
      if (w_ms_tick && (r_ms_cnt != 16'hFFFF)) begin
        r_ms_cnt <= r_ms_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    w_fault_entry = 1'b0;
    case (r_state)
      S_SETTLE: if (r_ms_cnt == C_T_SETTLE) w_next = S_RAMP;
      // pg_ok takes priority over a coincident timeout.
      S_RAMP: begin
        if (r_pg_ok) w_next = S_STABLE;
        else if (r_ms_cnt == C_T_TIMEOUT) w_fault_entry = 1'b1;
      end
      S_STABLE: begin
        if (!r_pg_ok) w_fault_entry = 1'b1;
        else if (r_ms_cnt == C_T_READY) w_next = S_READY;
      end
      S_READY:  if (!r_pg_ok) w_fault_entry = 1'b1;
      S_OFF:    if (r_ms_cnt == C_T_RETRY) w_next = S_RAMP;
      S_LOCK:   w_next = S_LOCK;
      default:  w_next = S_SETTLE;
    endcase
    if (w_fault_entry) begin
      w_next = (r_retry_cnt < C_MAX_RETRY) ? S_OFF : S_LOCK;
    end
  end

  // Outputs are registered from the next state so they change with the state itself.
  always_ff @(posedge clk100 or posedge pre_reset) begin
    if (pre_reset) begin
      r_state      <= S_SETTLE;
      r_v6_en      <= 1'b0;
      r_init_ready <= 1'b0;
      r_lockout    <= 1'b0;
      r_fault      <= 1'b0;
      r_retry_cnt  <= '0;
    end else begin
      r_state      <= w_next;
      r_v6_en      <= (w_next == S_RAMP) || (w_next == S_STABLE) || (w_next == S_READY);
      r_init_ready <= (w_next == S_READY);
      r_lockout    <= (w_next == S_LOCK);
      if (w_fault_entry) begin
        r_fault <= 1'b1;
        if (r_retry_cnt != 3'd7) r_retry_cnt <= r_retry_cnt + 3'd1;
      end
    end
  end

  assign v6_en      = r_v6_en;
  assign init_ready = r_init_ready;
  assign pg_ok      = r_pg_ok;
  assign fault      = r_fault;
  assign lockout    = r_lockout;
  assign retry_cnt  = r_retry_cnt;
  assign state      = r_state;

endmodule

`default_nettype wire

// File: tb/tb_power_sequencer.sv
// +----------------------------------------------------------------------------
// | Module   : tb_power_sequencer
// | Purpose  : Directed self-checking bench for power_sequencer (100 cycles per ms).
// | Revision : 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

module tb_power_sequencer;

  logic       clk100 = 1'b0;
  logic       pre_reset;
  logic       v3_pg;
  logic       v5p_pg;
  logic       v5n_pg;
  logic       v6_en;
  logic       init_ready;
  logic       pg_ok;
  logic       fault;
  logic       lockout;
  logic [2:0] retry_cnt;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  power_sequencer #(
    .CLK_PERIOD_NS  (10000),
    .T_SETTLE_MS    (2),
    .T_PG_TIMEOUT_MS(3),
    .T_READY_MS     (2),
    .T_RETRY_MS     (1),
    .MAX_RETRIES    (1),
    .PG_FILT        (16)
  ) dut (
    .clk100    (clk100),
    .pre_reset (pre_reset),
    .v3_pg     (v3_pg),
    .v5p_pg    (v5p_pg),
    .v5n_pg    (v5n_pg),
    .v6_en     (v6_en),
    .init_ready(init_ready),
    .pg_ok     (pg_ok),
    .fault     (fault),
    .lockout   (lockout),
    .retry_cnt (retry_cnt),
    .state     (state)
  );

  always #5 clk100 = ~clk100;

  task automatic step(input int n);
    repeat (n) @(posedge clk100);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_pg(input logic v);
    v3_pg  = v;
    v5p_pg = v;
    v5n_pg = v;
  endtask

  initial begin
    pre_reset = 1'b1;
    set_pg(1'b1);
    step(5);
    check("rst_v6_en", 32'(v6_en), 0);
    check("rst_init_ready", 32'(init_ready), 0);
    check("rst_pg_ok", 32'(pg_ok), 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_lockout", 32'(lockout), 0);
    check("rst_retry", 32'(retry_cnt), 0);
    check("rst_state", 32'(state), 0);

    // Nominal power-up, edges counted from reset release
    pre_reset = 1'b0;
    step(17);
    check("nom_pg_ok_e17", 32'(pg_ok), 0);
    step(1);
    check("nom_pg_ok_e18", 32'(pg_ok), 1);
    step(182);
    check("nom_v6_en_e200", 32'(v6_en), 0);
    check("nom_state_e200", 32'(state), 0);
    step(1);
    check("nom_v6_en_e201", 32'(v6_en), 1);
    check("nom_state_e201", 32'(state), 1);
    step(1);
    check("nom_state_e202", 32'(state), 2);
    step(200);
    check("nom_init_e402", 32'(init_ready), 0);
    step(1);
    check("nom_init_e403", 32'(init_ready), 1);
    check("nom_state_e403", 32'(state), 3);

    // Glitch shorter than the filter
    step(10);
    v5n_pg = 1'b0;
    step(10);
    v5n_pg = 1'b1;
    step(30);
    check("gl_pg_ok", 32'(pg_ok), 1);
    check("gl_init_ready", 32'(init_ready), 1);
    check("gl_fault", 32'(fault), 0);
    check("gl_state", 32'(state), 3);

    // Real fault in READY
    v3_pg = 1'b0;
    step(17);
    check("flt_pg_ok_f17", 32'(pg_ok), 1);
    step(1);
    check("flt_pg_ok_f18", 32'(pg_ok), 0);
    check("flt_init_f18", 32'(init_ready), 1);
    step(1);
    check("flt_init_f19", 32'(init_ready), 0);
    check("flt_v6_en_f19", 32'(v6_en), 0);
    check("flt_state_f19", 32'(state), 4);
    check("flt_fault_f19", 32'(fault), 1);
    check("flt_retry_f19", 32'(retry_cnt), 1);
    step(1);
    v3_pg = 1'b1;
    step(99);
    check("flt_state_f119", 32'(state), 4);
    step(1);
    check("flt_state_f120", 32'(state), 1);
    check("flt_v6_en_f120", 32'(v6_en), 1);
    step(1);
    check("flt_state_f121", 32'(state), 2);

    // Asynchronous reset in STABLE
    step(50);
    check("ar_state_pre", 32'(state), 2);
    pre_reset = 1'b1;
    #1;
    check("ar_v6_en", 32'(v6_en), 0);
    check("ar_state", 32'(state), 0);
    check("ar_fault", 32'(fault), 0);
    check("ar_retry", 32'(retry_cnt), 0);
    check("ar_pg_ok", 32'(pg_ok), 0);
    step(3);
    pre_reset = 1'b0;
    step(200);
    check("ar_v6_en_e200", 32'(v6_en), 0);
    step(1);
    check("ar_v6_en_e201", 32'(v6_en), 1);
    check("ar_state_e201", 32'(state), 1);

    // Lockout: PG never comes up
    pre_reset = 1'b1;
    set_pg(1'b0);
    step(3);
    pre_reset = 1'b0;
    step(201);
    check("lk_state_e201", 32'(state), 1);
    step(300);
    check("lk_state_e501", 32'(state), 1);
    step(1);
    check("lk_state_e502", 32'(state), 4);
    check("lk_retry_e502", 32'(retry_cnt), 1);
    check("lk_fault_e502", 32'(fault), 1);
    check("lk_v6_en_e502", 32'(v6_en), 0);
    step(101);
    check("lk_state_e603", 32'(state), 1);
    check("lk_v6_en_e603", 32'(v6_en), 1);
    step(300);
    check("lk_state_e903", 32'(state), 1);
    step(1);
    check("lk_state_e904", 32'(state), 5);
    check("lk_lockout_e904", 32'(lockout), 1);
    check("lk_retry_e904", 32'(retry_cnt), 2);
    check("lk_v6_en_e904", 32'(v6_en), 0);
    set_pg(1'b1);
    step(300);
    check("lk_pg_ok_late", 32'(pg_ok), 1);
    check("lk_v6_en_late", 32'(v6_en), 0);
    check("lk_state_late", 32'(state), 5);

    // Race: pg_ok arrives on the exact RAMP timeout cycle
    pre_reset = 1'b1;
    set_pg(1'b0);
    step(3);
    pre_reset = 1'b0;
    step(483);
    set_pg(1'b1);
    step(17);
    check("rc_pg_ok_e500", 32'(pg_ok), 0);
    check("rc_state_e500", 32'(state), 1);
    step(1);
    check("rc_pg_ok_e501", 32'(pg_ok), 1);
    check("rc_state_e501", 32'(state), 1);
    step(1);
    check("rc_state_e502", 32'(state), 2);
    check("rc_fault_e502", 32'(fault), 0);
    check("rc_retry_e502", 32'(retry_cnt), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
